// File: rtl/alu_pkg.sv
// Shared status-word layout for the ALU datapath blocks.
// Bit positions in the 4-bit status word produced alongside each ALU result.
package alu_pkg;
    localparam int STATUS_W  = 4;
    localparam int STAT_ERR  = 0;
    localparam int STAT_NEG  = 1;
    localparam int STAT_PAR  = 2;
    localparam int STAT_ONES = 3;

    function automatic logic is_error(input logic [STATUS_W-1:0] status);
        return status[STAT_ERR];
    endfunction
endpackage

// File: rtl/alu_sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides the increment.
module alu_sat_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);
    localparam logic [W-1:0] MAX_CNT = '1;

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != MAX_CNT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/alu_result_buffer.sv
// Show-ahead FIFO for ALU result/status words with an error-word counter.
// Handshake flags come only from registered occupancy, so no input-to-output paths exist.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int m = 4,
    parameter int n = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [m-1:0]        i_result,
    input  logic [STATUS_W-1:0] i_status,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [m-1:0]        o_result,
    output logic [STATUS_W-1:0] o_status,
    output logic [n:0]          o_count,
    output logic [7:0]          o_err_cnt,
    input  logic                i_clr_err
);
    localparam int         DEPTH    = 2 ** n;
    localparam logic [n:0] FULL_CNT = (n + 1)'(DEPTH);

    typedef struct packed {
        logic [STATUS_W-1:0] status;
        logic [m-1:0]        result;
    } entry_t;

    entry_t       r_mem [DEPTH];
    logic [n-1:0] r_wr_ptr;
    logic [n-1:0] r_rd_ptr;
    logic [n:0]   r_count;

    logic   w_push;
    logic   w_pop;
    logic   w_err_push;
    entry_t w_wr_entry;
    entry_t w_head;

    assign o_ready    = (r_count < FULL_CNT);
    assign o_valid    = (r_count != '0);
    assign w_push     = i_valid && o_ready;
    assign w_pop      = o_valid && i_ready;
    assign w_err_push = w_push && is_error(i_status);

    // Error words carry undefined data, so only their status is kept.
    always_comb begin
        w_wr_entry.status = i_status;
        w_wr_entry.result = is_error(i_status) ? '0 : i_result;
    end

    // Storage has no reset; emptiness is tracked by r_count and masks the outputs.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head   = r_mem[r_rd_ptr];
    assign o_result = o_valid ? w_head.result : '0;
    assign o_status = o_valid ? w_head.status : '0;
    assign o_count  = r_count;

    alu_sat_counter #(
        .W(8)
    ) u_err_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (w_err_push),
        .i_clr (i_clr_err),
        .o_cnt (o_err_cnt)
    );
endmodule

// File: tb/tb_alu_result_buffer.sv
// Scoreboard bench for alu_result_buffer: expected {status,result} words are queued
// when a push is accepted and compared against the head when the DUT presents it.
module tb_alu_result_buffer;
    logic       clk = 1'b0;
    logic       rst;
    logic       i_valid;
    logic       o_ready;
    logic [3:0] i_result;
    logic [3:0] i_status;
    logic       o_valid;
    logic       i_ready;
    logic [3:0] o_result;
    logic [3:0] o_status;
    logic [2:0] o_count;
    logic [7:0] o_err_cnt;
    logic       i_clr_err;

    int passed = 0;
    int total  = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    alu_result_buffer #(.m(4), .n(2)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_result  (i_result),
        .i_status  (i_status),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_result  (o_result),
        .o_status  (o_status),
        .o_count   (o_count),
        .o_err_cnt (o_err_cnt),
        .i_clr_err (i_clr_err)
    );

    // One clock of stimulus; scoreboard bookkeeping follows the handshake rules.
    task automatic drive(input logic v, input logic [3:0] res, input logic [3:0] st,
                         input logic rdy, input logic clr);
        logic will_push;
        logic will_pop;
        i_valid   = v;
        i_result  = res;
        i_status  = st;
        i_ready   = rdy;
        i_clr_err = clr;
        will_push = v && (exp_q.size() < 4);
        will_pop  = rdy && (exp_q.size() != 0);
        @(posedge clk);
        #1;
        if (will_pop) void'(exp_q.pop_front());
        if (will_push) exp_q.push_back({st, st[0] ? 4'h0 : res});
        $display("txn t=%0t push=%0b pop=%0b res=%h st=%h -> count=%0d head=%h/%h err=%0d",
                 $time, will_push, will_pop, res, st, o_count, o_status, o_result, o_err_cnt);
        i_valid   = 1'b0;
        i_ready   = 1'b0;
        i_clr_err = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({o_valid, o_ready, o_count} !== {1'b0, 1'b1, 3'd0})
            $display("FAIL reset_flags: valid/ready/count=%b/%b/%0d expected 0/1/0", o_valid, o_ready, o_count);
        else passed++;
        total++;
        if ({o_status, o_result, o_err_cnt} !== 16'h0)
            $display("FAIL reset_outputs: status=%h result=%h err=%0d expected 0/0/0", o_status, o_result, o_err_cnt);
        else passed++;
    endtask

    task automatic test_first_push();
        drive(1'b1, 4'b0011, 4'b0100, 1'b0, 1'b0);
        total++;
        if ({o_valid, o_count} !== {1'b1, 3'd1})
            $display("FAIL first_push_flags: valid=%b count=%0d expected 1/1", o_valid, o_count);
        else passed++;
        total++;
        if ({o_status, o_result} !== exp_q[0] || exp_q[0] !== 8'h43)
            $display("FAIL first_push_data: got %h expected %h", {o_status, o_result}, 8'h43);
        else passed++;
        drive(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        total++;
        if ({o_valid, o_count, o_status, o_result} !== 12'h0)
            $display("FAIL empty_mask: valid=%b count=%0d data=%h expected all 0", o_valid, o_count, {o_status, o_result});
        else passed++;
    endtask

    task automatic test_fill_hold();
        for (int k = 1; k <= 4; k++) drive(1'b1, 4'(k), 4'h0, 1'b0, 1'b0);
        total++;
        if ({o_ready, o_count} !== {1'b0, 3'd4})
            $display("FAIL fill: ready=%b count=%0d expected 0/4", o_ready, o_count);
        else passed++;
        drive(1'b1, 4'd9, 4'h0, 1'b0, 1'b0);
        drive(1'b1, 4'd9, 4'h0, 1'b0, 1'b0);
        total++;
        if (o_count !== 3'd4)
            $display("FAIL hold_count: count=%0d expected 4", o_count);
        else passed++;
        for (int k = 1; k <= 4; k++) begin
            total++;
            if (o_valid !== 1'b1 || {o_status, o_result} !== {4'h0, 4'(k)})
                $display("FAIL drain_order[%0d]: valid=%b got %h expected %h", k, o_valid, {o_status, o_result}, {4'h0, 4'(k)});
            else passed++;
            drive(1'b1 == 1'b0, 4'd0, 4'h0, 1'b1, 1'b0);
        end
        total++;
        if ({o_valid, o_count} !== {1'b0, 3'd0})
            $display("FAIL drain_empty: valid=%b count=%0d expected 0/0 (word 9 leaked?)", o_valid, o_count);
        else passed++;
    endtask

    task automatic test_full_push_pop();
        for (int k = 5; k <= 8; k++) drive(1'b1, 4'(k), 4'h2, 1'b0, 1'b0);
        total++;
        if ({o_status, o_result} !== 8'h25)
            $display("FAIL full_head: got %h expected 25", {o_status, o_result});
        else passed++;
        drive(1'b1, 4'hA, 4'h0, 1'b1, 1'b0);
        total++;
        if ({o_count, o_ready} !== {3'd3, 1'b1})
            $display("FAIL full_pushpop: count=%0d ready=%b expected 3/1", o_count, o_ready);
        else passed++;
        while (exp_q.size() != 0) begin
            total++;
            if ({o_status, o_result} !== exp_q[0] || exp_q[0][3:0] == 4'hA)
                $display("FAIL full_drain: got %h expected %h", {o_status, o_result}, exp_q[0]);
            else passed++;
            drive(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_stream();
        drive(1'b1, 4'hC, 4'h8, 1'b0, 1'b0);
        drive(1'b1, 4'hD, 4'h2, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            logic [3:0] st;
            st = 4'($urandom_range(0, 15)) & 4'hE;
            total++;
            if (o_count !== 3'd2 || {o_status, o_result} !== exp_q[0])
                $display("FAIL stream[%0d]: count=%0d got %h expected 2/%h", k, o_count, {o_status, o_result}, exp_q[0]);
            else passed++;
            drive(1'b1, 4'(k), st, 1'b1, 1'b0);
        end
        while (exp_q.size() != 0) begin
            total++;
            if ({o_status, o_result} !== exp_q[0])
                $display("FAIL stream_drain: got %h expected %h", {o_status, o_result}, exp_q[0]);
            else passed++;
            drive(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_err_cnt();
        do_reset();
        drive(1'b1, 4'b1010, 4'b0001, 1'b0, 1'b0);
        total++;
        if ({o_status, o_result} !== 8'h10 || o_err_cnt !== 8'd1)
            $display("FAIL err_store: data=%h err=%0d expected 10/1", {o_status, o_result}, o_err_cnt);
        else passed++;
        drive(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        for (int k = 0; k < 300; k++) drive(1'b1, 4'hF, 4'h1, 1'b1, 1'b0);
        total++;
        if (o_err_cnt !== 8'd255)
            $display("FAIL err_saturate: err=%0d expected 255", o_err_cnt);
        else passed++;
        drive(1'b1, 4'h5, 4'h4, 1'b1, 1'b0);
        total++;
        if (o_err_cnt !== 8'd255)
            $display("FAIL err_clean_push: err=%0d expected 255", o_err_cnt);
        else passed++;
        drive(1'b1, 4'hF, 4'h1, 1'b1, 1'b1);
        total++;
        if (o_err_cnt !== 8'd0)
            $display("FAIL err_clear_priority: err=%0d expected 0", o_err_cnt);
        else passed++;
        drive(1'b1, 4'hF, 4'h1, 1'b1, 1'b0);
        total++;
        if (o_err_cnt !== 8'd1 || {o_status, o_result} !== exp_q[0])
            $display("FAIL err_after_clear: err=%0d data=%h expected 1/%h", o_err_cnt, {o_status, o_result}, exp_q[0]);
        else passed++;
        while (exp_q.size() != 0) drive(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        drive(1'b1, 4'h1, 4'h1, 1'b0, 1'b0);
        drive(1'b1, 4'h2, 4'h0, 1'b0, 1'b0);
        drive(1'b1, 4'h3, 4'h0, 1'b0, 1'b0);
        total++;
        if (o_count !== 3'd3 || o_err_cnt === 8'd0)
            $display("FAIL pre_async: count=%0d err=%0d expected 3/nonzero", o_count, o_err_cnt);
        else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({o_count, o_valid, o_err_cnt, o_result, o_status} !== 20'h0 || o_ready !== 1'b1)
            $display("FAIL async_reset: count=%0d valid=%b err=%0d data=%h ready=%b expected 0/0/0/00/1",
                     o_count, o_valid, o_err_cnt, {o_status, o_result}, o_ready);
        else passed++;
        #2 rst = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        drive(1'b1, 4'h7, 4'h8, 1'b0, 1'b0);
        total++;
        if ({o_count, o_status, o_result} !== {3'd1, 8'h87})
            $display("FAIL post_async_push: count=%0d data=%h expected 1/87", o_count, {o_status, o_result});
        else passed++;
    endtask

    initial begin
        rst       = 1'b0;
        i_valid   = 1'b0;
        i_ready   = 1'b0;
        i_result  = 4'h0;
        i_status  = 4'h0;
        i_clr_err = 1'b0;
        #2;
        test_reset();
        test_first_push();
        test_fill_hold();
        test_full_push_pop();
        test_stream();
        test_err_cnt();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 The block SHALL have parameter m, default 4, giving the data width of result words, matching the ALU operation units.
REQ-002 The block SHALL have parameter n, default 2, giving the buffer address width, so depth is 2**n (4) entries.
REQ-003 The block SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1, reset, asynchronous and active-high.
REQ-005 The block SHALL have port i_valid, input, 1, upstream word on i_result/i_status is valid.
REQ-006 The block SHALL have port o_ready, output, 1, the buffer can accept a word this cycle.
REQ-007 The block SHALL have port i_result, input, m, the ALU result word.
REQ-008 The block SHALL have port i_status, input, 4, the ALU status {all-ones, even parity, negative, error} for bits [3:0].
REQ-009 The block SHALL have port o_valid, output, 1, the head entry is valid.
REQ-010 The block SHALL have port i_ready, input, 1, the downstream consumer takes the head entry.
REQ-011 The block SHALL have port o_result, output, m, the head entry result.
REQ-012 The block SHALL have port o_status, output, 4, the head entry status.
REQ-013 The block SHALL have port o_count, output, n+1, the current occupancy, 0..2**n.
REQ-014 The block SHALL have port o_err_cnt, output, 8, the count of accepted words with the error bit set.
REQ-015 The block SHALL have port i_clr_err, input, 1, synchronous clear of o_err_cnt.

Function
REQ-016 A push SHALL occur when i_valid && o_ready; a pop SHALL occur when o_valid && i_ready.
REQ-017 o_ready SHALL be 1 exactly when o_count < 2**n; o_valid SHALL be 1 exactly when o_count != 0, both decoded from registered occupancy only (no combinational path from i_valid/i_ready).
REQ-018 Show-ahead: o_result/o_status SHALL present the oldest stored entry whenever o_valid=1, and SHALL be '0 when empty.
REQ-019 Latency push-to-o_valid SHALL be 1 cycle; there is no same-cycle bypass from input to output.
REQ-020 A push with i_status[0]=1 SHALL store i_result as '0, because error words carry undefined data; i_status is stored unchanged.
REQ-021 Simultaneous push and pop SHALL leave o_count unchanged and advance both pointers.
REQ-022 When full, i_valid SHALL be ignored even if i_ready=1 in the same cycle; the pop proceeds and o_ready rises the next cycle.
REQ-023 When empty, i_ready SHALL be ignored and the pointers SHALL not move.
REQ-024 Write and read pointers SHALL be n bits and SHALL wrap modulo 2**n.
REQ-025 o_err_cnt SHALL increment by 1 on each push with i_status[0]=1 and saturate at 255.
REQ-026 i_clr_err SHALL take priority over the increment: clear and error-push in the same cycle SHALL give 0.

Reset
REQ-027 Asserting i_rst SHALL immediately clear the pointers, o_count, and o_err_cnt to 0, giving o_valid=0, o_ready=1, o_result='0, and o_status='0.
REQ-028 Reset mid-operation SHALL discard all stored entries; storage contents need no reset, but outputs SHALL be masked to '0 while empty.

Structure
REQ-029 Package alu_pkg SHALL hold STATUS_W=4 and the status bit indices STAT_ERR=0, STAT_NEG=1, STAT_PAR=2, and STAT_ONES=3.
REQ-030 The saturating error counter SHALL be a sub-module, alu_sat_counter, with width parameter 8, inc, clr, and the same clock and reset.
REQ-031 Storage SHALL be a 2**n-entry array of {status, result}, with the occupancy counter held separately from the pointers.

Verification
REQ-032 The bench SHALL cover reset then push result=4'b0011/status=4'b0100: o_valid=1 one cycle later, o_result=3, o_status=4, o_count=1.
REQ-033 The bench SHALL cover 4 pushes 1,2,3,4 with i_ready=0 giving o_ready=0 and o_count=4, then a 5th word 9 held; draining SHALL return 1,2,3,4 in order and 9 SHALL never appear.
REQ-034 The bench SHALL cover full, with i_valid=1 and i_ready=1 for 1 cycle: word popped, input not accepted, o_count=3, o_ready=1 next cycle.
REQ-035 The bench SHALL cover a half-full buffer with continuous push and pop for 10 cycles (pointer wrap): o_count stays constant and the output order matches the input.
REQ-036 The bench SHALL cover a push with status=4'b0001 and result=4'b1010: stored result=0 and o_err_cnt=1; 300 error pushes SHALL give o_err_cnt=255; i_clr_err with an error push SHALL give 0.
REQ-037 The bench SHALL cover i_rst asserted asynchronously with 3 entries stored: o_count=0, o_valid=0, and o_err_cnt=0 before the next clock edge.
